// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared cipher alphabet, legality check and sequencer state encoding
package decode_pkg;

  typedef enum logic [7:0] {
    CH_I = 8'h49, CH_A = 8'h41, CH_H = 8'h48, CH_U = 8'h55,
    CH_O = 8'h4F, CH_T = 8'h54, CH_D = 8'h44, CH_N = 8'h4E,
    CH_S = 8'h53, CH_L = 8'h4C, CH_R = 8'h52, CH_E = 8'h45
  } ALPHA_T;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} DSC_STATE_T;

  localparam logic [7:0] ILLEGAL_SUB = 8'h3F;

  function automatic logic IS_CIPHER(input logic [7:0] c);
    case (c)
      8'h49, 8'h41, 8'h48, 8'h55, 8'h4F, 8'h54,
      8'h44, 8'h4E, 8'h53, 8'h4C, 8'h52, 8'h45: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/DECODER.sv
// rtl/DECODER.sv - combinational cipher-to-plain letter substitution
module DECODER
  import decode_pkg::*;
(
  input  ALPHA_T CIPHER,
  output ALPHA_T PLAIN
);

  // Cipher letters ranked by frequency map onto the English ranking E,T,A,O,I,N,S,H,R,D,L,U.
  always_comb begin
    PLAIN = CIPHER;
    case (CIPHER)
      CH_I: PLAIN = CH_E;
      CH_A: PLAIN = CH_T;
      CH_H: PLAIN = CH_A;
      CH_U: PLAIN = CH_O;
      CH_O: PLAIN = CH_I;
      CH_T: PLAIN = CH_N;
      CH_D: PLAIN = CH_S;
      CH_N: PLAIN = CH_H;
      CH_S: PLAIN = CH_R;
      CH_L: PLAIN = CH_D;
      CH_R: PLAIN = CH_L;
      CH_E: PLAIN = CH_U;
      default: PLAIN = CIPHER;
    endcase
  end

endmodule

// File: rtl/decode_fifo.sv
// rtl/decode_fifo.sv - synchronous FIFO with wrap-bit pointers for full/empty detection
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/decode_stream_ctrl.sv
// rtl/decode_stream_ctrl.sv - message sequencer around DECODER; DECODE_STREAM_PASSTHRU_EN forwards illegal bytes unchanged
module decode_stream_ctrl
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       IN_CHAR,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [7:0]       OUT_CHAR,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  input  logic             OUT_READY,
  output logic             MSG_DONE,
  output logic [LEN_W-1:0] MSG_LEN,
  output logic [LEN_W-1:0] MSG_CNT,
  output logic [LEN_W-1:0] ILLEGAL_CNT,
  output logic             BUSY
);

  DSC_STATE_T       state_q, state_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic [LEN_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [LEN_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             msg_done_q, msg_done_d;

  logic       fifo_full, fifo_empty;
  logic [8:0] fifo_rdata;
  ALPHA_T     plain;
  logic       legal;
  logic [7:0] push_char;
  logic       accept, out_hs, last_hs;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + {{(LEN_W-1){1'b0}}, 1'b1};
  endfunction

  assign legal = IS_CIPHER(IN_CHAR);

  DECODER u_decoder (
    .CIPHER (ALPHA_T'(IN_CHAR)),
    .PLAIN  (plain)
  );

  always_comb begin
    push_char = plain;
    if (!legal) begin
`ifdef DECODE_STREAM_PASSTHRU_EN
      push_char = IN_CHAR;
`else
      push_char = ILLEGAL_SUB;
`endif
    end
  end

  // Readiness depends only on registered state, never on OUT_READY.
  assign IN_READY  = !RST && !fifo_full && (state_q != DRAIN);
  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = !fifo_empty;
  assign OUT_CHAR  = fifo_empty ? 8'h00 : fifo_rdata[7:0];
  assign OUT_LAST  = !fifo_empty && fifo_rdata[8];
  assign out_hs    = OUT_VALID && OUT_READY;
  assign last_hs   = out_hs && OUT_LAST;

  decode_fifo #(
    .DEPTH (DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (accept),
    .wdata ({IN_LAST, push_char}),
    .pop   (OUT_READY),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    msg_len_d     = msg_len_q;
    msg_cnt_d     = msg_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    msg_done_d    = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = IN_LAST ? DRAIN : RUN;
      RUN:     if (accept && IN_LAST) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) beat_cnt_d = sat_inc(beat_cnt_q);
    if (accept && !legal) illegal_cnt_d = sat_inc(illegal_cnt_q);
    // No beat can be accepted while draining, so beat_cnt_q is final here.
    if (last_hs) begin
      msg_len_d  = beat_cnt_q;
      msg_cnt_d  = sat_inc(msg_cnt_q);
      msg_done_d = 1'b1;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      msg_len_q     <= '0;
      msg_cnt_q     <= '0;
      illegal_cnt_q <= '0;
      msg_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      msg_len_q     <= msg_len_d;
      msg_cnt_q     <= msg_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
      msg_done_q    <= msg_done_d;
    end
  end

  assign MSG_DONE    = msg_done_q;
  assign MSG_LEN     = msg_len_q;
  assign MSG_CNT     = msg_cnt_q;
  assign ILLEGAL_CNT = illegal_cnt_q;
  assign BUSY        = (state_q != IDLE);

endmodule

// File: doc/decode_stream_ctrl.md
Name: decode_stream_ctrl

Overview:
- Message-level sequencer for the existing combinational DECODER (ALPHA_T CIPHER -> ALPHA_T PLAIN).
- Accepts a stream of 8-bit ASCII cipher characters over a valid/ready handshake and validates each against the twelve cipher letters I,A,H,U,O,T,D,N,S,L,R,E.
- Drives DECODER, buffers plaintext in a small FIFO, and emits it over a valid/ready handshake with message framing, per-message length and illegal-character statistics.
- Sits between a character source (UART/ROM reader) and a plaintext sink.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- LEN_W, 8, width of the MSG_LEN, MSG_CNT and ILLEGAL_CNT counters.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_CHAR  in  8  ASCII cipher character.
- IN_VALID  in  1  IN_CHAR/IN_LAST valid.
- IN_LAST  in  1  marks the final character of a message.
- IN_READY  out  1  block accepts a beat this cycle.
- OUT_CHAR  out  8  plaintext character.
- OUT_VALID  out  1  OUT_CHAR/OUT_LAST valid.
- OUT_LAST  out  1  final plaintext character of the message.
- OUT_READY  in  1  sink accepts a beat.
- MSG_DONE  out  1  one-cycle pulse on the OUT_LAST handshake.
- MSG_LEN  out  LEN_W  beat count of the last completed message.
- MSG_CNT  out  LEN_W  number of completed messages.
- ILLEGAL_CNT  out  LEN_W  illegal characters seen since reset.
- BUSY  out  1  state is not IDLE.

Behaviour:
- Handshakes:
  - Input beat accepted when IN_VALID && IN_READY.
  - Output beat transfers when OUT_VALID && OUT_READY.
  - OUT_CHAR and OUT_LAST are held stable while OUT_VALID && !OUT_READY.
- IN_READY = !RST && !fifo_full && state != DRAIN.
  - No combinational path from OUT_READY to IN_READY.
  - When full, a pop in the same cycle does not enable a push.
- Legal character: cast to ALPHA_T, driven on DECODER.CIPHER; DECODER.PLAIN is pushed with IN_LAST.
- Illegal character (any byte outside the 12 letters):
  - 8'h3F ('?') is pushed in its place, so one input beat always yields exactly one output beat.
  - ILLEGAL_CNT increments.
- Latency: a beat accepted in cycle N shows OUT_VALID in cycle N+1 (registered FIFO storage; OUT_VALID = !fifo_empty). Order is preserved.
- FSM:
  - IDLE -> RUN on an accepted beat without IN_LAST.
  - IDLE or RUN -> DRAIN on an accepted beat with IN_LAST.
  - DRAIN -> IDLE on the OUT_LAST handshake.
  - IN_READY is 0 in DRAIN, so messages never interleave.
- Per-message counter:
  - Resets to 0 on entry to IDLE and increments on each accepted beat.
  - On the OUT_LAST handshake, MSG_LEN latches the beat count, MSG_CNT increments and MSG_DONE pulses.
- All counters saturate at all-ones.
- Single-beat message (first beat has IN_LAST): IDLE -> DRAIN directly; MSG_LEN = 1.
- Reset (including mid-message):
  - FIFO emptied; state IDLE.
  - OUT_VALID, OUT_LAST, MSG_DONE, BUSY, IN_READY = 0.
  - OUT_CHAR = 8'h00; all counters 0.
  - Any partial message is discarded.
- The first accept is possible in the first cycle after RST deasserts.

Optional Feature:
- Macro: DECODE_STREAM_PASSTHRU_EN.
- Defined: an illegal character is pushed unchanged (e.g. 'X' -> 8'h58); ILLEGAL_CNT still increments.
- Undefined: an illegal character is replaced by 8'h3F.

Decomposition:
- Shared package decode_pkg holds:
  - existing ALPHA_T;
  - function IS_CIPHER(byte) returning the legality of a character;
  - constant ILLEGAL_SUB = 8'h3F;
  - state enum DSC_STATE_T {IDLE, RUN, DRAIN}.
- Sub-module decode_fifo: synchronous FIFO of DEPTH x 9 bits (char + last), with full/empty flags and wrap-around pointers plus one extra wrap bit.
- DECODER is instantiated unchanged inside decode_stream_ctrl.

Test Plan:
- Reset: hold RST for 2 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, all counters 0; IN_READY=1 in the first cycle after release.
- Full message: "HAAITAOUTHRRETOAD" (17 beats, IN_LAST on 'D'), OUT_READY=1 -> 17 output beats equal to the DECODER reference model, first OUT_VALID 1 cycle after the first accept, OUT_LAST on beat 17, one MSG_DONE pulse, MSG_LEN=17, MSG_CNT=1.
- Backpressure: DEPTH=4, OUT_READY=0, offer 6 beats -> 4 accepted then IN_READY=0; raise OUT_READY -> all 6 emerge in order, OUT_CHAR stable during the stall.
- Illegal character: "HXA" with IN_LAST on 'A' -> DEC('H'), 8'h3F, DEC('A'); ILLEGAL_CNT=1, MSG_LEN=3. With DECODE_STREAM_PASSTHRU_EN, the middle beat is 8'h58.
- Drain gating: after an IN_LAST accept, OUT_READY=0 for 5 cycles while the next message is offered -> IN_READY=0 until the OUT_LAST handshake; the next message's first beat is accepted in the following cycle.
- Reset mid-message: RST pulsed for 1 cycle after 3 of 10 beats -> FIFO empty, counters 0; a fresh "HRISARHDISDHAIRROAIDAU" decodes cleanly with MSG_LEN=22 and MSG_CNT=1.
